// File: rtl/wb_rr_arbiter_wdog_if.sv
// Bus bundle for the round-robin Wishbone arbiter: the master-side arrays
// (one packed slice per requesting master) and the single shared slave port.
// The arbiter takes the "slave" modport (it is the slave of the master array);
// the surrounding environment takes the "master" modport.
interface wb_rr_arbiter_wdog_if #(
  parameter int N_MASTERS     = 4,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32
);
  localparam int SEL_W = WB_DATA_WIDTH / 8;

  // Requesting masters
  logic [N_MASTERS-1:0]               m_cyc;
  logic [N_MASTERS-1:0]               m_stb;
  logic [N_MASTERS-1:0]               m_we;
  logic [N_MASTERS*WB_ADDR_WIDTH-1:0] m_adr;
  logic [N_MASTERS*WB_DATA_WIDTH-1:0] m_dat_w;
  logic [N_MASTERS*SEL_W-1:0]         m_sel;
  logic [3*N_MASTERS-1:0]             m_cti;
  logic [2*N_MASTERS-1:0]             m_bte;
  logic [WB_DATA_WIDTH-1:0]           m_dat_r;
  logic [N_MASTERS-1:0]               m_ack;
  logic [N_MASTERS-1:0]               m_err;

  // Shared slave port
  logic                               s_cyc;
  logic                               s_stb;
  logic                               s_we;
  logic [WB_ADDR_WIDTH-1:0]           s_adr;
  logic [WB_DATA_WIDTH-1:0]           s_dat_w;
  logic [SEL_W-1:0]                   s_sel;
  logic [2:0]                         s_cti;
  logic [1:0]                         s_bte;
  logic [WB_DATA_WIDTH-1:0]           s_dat_r;
  logic                               s_ack;
  logic                               s_err;

  modport slave (
    input  m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel, m_cti, m_bte,
    output m_dat_r, m_ack, m_err,
    output s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel, s_cti, s_bte,
    input  s_dat_r, s_ack, s_err
  );

  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel, m_cti, m_bte,
    input  m_dat_r, m_ack, m_err,
    input  s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel, s_cti, s_bte,
    output s_dat_r, s_ack, s_err
  );
endinterface

// File: rtl/wb_rr_arbiter_wdog.sv
// N-master to 1-slave Wishbone arbiter.
// A master is granted on CYC alone, round-robin starting after the previous
// owner, and keeps the slave until it drops CYC, so bursts and locked cycles
// are never interleaved. The shared slave port is a pure combinational mux of
// the owner's signals. A watchdog counts stalled STB cycles; on expiry the
// owner gets ERR for one cycle, the slave is released and the arbiter waits
// in ABORT until the owner drops CYC.
module wb_rr_arbiter_wdog #(
  parameter int N_MASTERS     = 4,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int TIMEOUT       = 255
) (
  input  logic                         clk,
  input  logic                         rstn,
  wb_rr_arbiter_wdog_if.slave          bus,
  output logic                         gnt_valid,
  output logic [$clog2(N_MASTERS)-1:0] gnt_id,
  output logic                         timeout_evt
);

  localparam int ID_W  = $clog2(N_MASTERS);
  localparam int SEL_W = WB_DATA_WIDTH / 8;
  // Counter only needs to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  // Pointer resets to the top master so the first search starts at master 0.
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_MASTERS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [ID_W-1:0]  gnt_q;
  logic [ID_W-1:0]  last_q;
  logic [ID_W-1:0]  pick;
  logic             take;
  logic             own_cyc;
  logic             own_stb;
  logic             stalled;
  logic             wd_fire;
  logic [CNT_W-1:0] wd_cnt_q;
  logic [CNT_W-1:0] wd_cnt_d;

  // First requester after 'last', wrapping around; returns 'last' when none.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                               input logic [ID_W-1:0]      last);
    logic [ID_W-1:0] sel;
    logic [ID_W-1:0] idx;
    logic            found;
    sel   = last;
    found = 1'b0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      idx = ID_W'((int'(last) + k) % N_MASTERS);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign own_cyc = bus.m_cyc[gnt_q];
  assign own_stb = bus.m_stb[gnt_q];
  assign take    = (state_q == IDLE) && (|bus.m_cyc);

  // Arbitration decision and watchdog terminal-count detection.
  always_comb begin
    pick     = rr_pick(bus.m_cyc, last_q);
    stalled  = (state_q == GRANT) && own_stb && !bus.s_ack && !bus.s_err;
    wd_fire  = (TIMEOUT != 0) && stalled && (wd_cnt_q == WD_LAST);
    wd_cnt_d = '0;
    if ((TIMEOUT != 0) && stalled && !wd_fire) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant owner and round-robin pointer; both move only when a grant is made.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gnt_q  <= '0;
      last_q <= LAST_RST;
    end else if (take) begin
      gnt_q  <= pick;
      last_q <= pick;
    end
  end

  // Watchdog counter; cleared whenever the owner is not stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  // Next-state logic. Dropping CYC takes priority over an abort.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!own_cyc) begin
          state_d = IDLE;
        end else if (wd_fire) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        if (!own_cyc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus mux and response routing, decoded from the current state.
  always_comb begin
    bus.m_dat_r = bus.s_dat_r;
    bus.m_ack   = '0;
    bus.m_err   = '0;
    bus.s_cyc   = 1'b0;
    bus.s_stb   = 1'b0;
    bus.s_we    = 1'b0;
    bus.s_adr   = '0;
    bus.s_dat_w = '0;
    bus.s_sel   = '0;
    bus.s_cti   = '0;
    bus.s_bte   = '0;
    gnt_valid   = 1'b0;
    timeout_evt = 1'b0;
    case (state_q)
      GRANT: begin
        gnt_valid          = 1'b1;
        bus.s_cyc          = own_cyc;
        bus.s_stb          = own_stb;
        bus.s_we           = bus.m_we[gnt_q];
        bus.s_adr          = bus.m_adr[gnt_q*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
        bus.s_dat_w        = bus.m_dat_w[gnt_q*WB_DATA_WIDTH +: WB_DATA_WIDTH];
        bus.s_sel          = bus.m_sel[gnt_q*SEL_W +: SEL_W];
        bus.s_cti          = bus.m_cti[gnt_q*3 +: 3];
        bus.s_bte          = bus.m_bte[gnt_q*2 +: 2];
        bus.m_ack[gnt_q]   = bus.s_ack;
        bus.m_err[gnt_q]   = bus.s_err | wd_fire;
        timeout_evt        = wd_fire;
      end
      ABORT: begin
        // Slave released; late responses are dropped.
        gnt_valid = 1'b1;
      end
      default: begin
      end
    endcase
    gnt_id = gnt_valid ? gnt_q : '0;
  end

endmodule

// File: tb/tb_wb_rr_arbiter_wdog.sv
// Testbench for wb_rr_arbiter_wdog: per-cycle vector table for arbitration,
// round-robin order and watchdog behaviour, plus hand sequences for the
// burst hold and the asynchronous reset.
module tb_wb_rr_arbiter_wdog;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic       clk;
  logic       rstn;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       timeout_evt;

  wb_rr_arbiter_wdog_if #(.N_MASTERS(NM), .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW)) bus ();

  wb_rr_arbiter_wdog #(
    .N_MASTERS(NM), .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus.slave),
    .gnt_valid   (gnt_valid),
    .gnt_id      (gnt_id),
    .timeout_evt (timeout_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rn;
    logic [3:0] cyc;
    logic [3:0] stb;
    logic       ack;
    logic       err;
    logic       e_gv;
    logic [1:0] e_id;
    logic       e_scyc;
    logic       e_sstb;
    logic [3:0] e_mack;
    logic [3:0] e_merr;
    logic       e_to;
  } vec_t;

  vec_t vq[$];
  int   n_chk;
  int   n_fail;

  task automatic add(input logic rn, input logic [3:0] cyc, input logic [3:0] stb,
                     input logic ack, input logic err,
                     input logic gv, input logic [1:0] id, input logic sc, input logic ss,
                     input logic [3:0] mack, input logic [3:0] merr, input logic to);
    vec_t v;
    v.rn = rn; v.cyc = cyc; v.stb = stb; v.ack = ack; v.err = err;
    v.e_gv = gv; v.e_id = id; v.e_scyc = sc; v.e_sstb = ss;
    v.e_mack = mack; v.e_merr = merr; v.e_to = to;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] ctrl_now();
    return {gnt_valid, gnt_id, bus.s_cyc, bus.s_stb, bus.m_ack, bus.m_err, timeout_evt};
  endfunction

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish expected finish before 200000");
    $fatal(1, "simulation time limit");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rstn   = 1'b0;
    bus.m_cyc = '0; bus.m_stb = '0; bus.m_we = 4'b1010;
    bus.m_cti = '0; bus.m_adr = '0; bus.m_dat_w = '0; bus.m_sel = '0; bus.m_bte = '0;
    bus.s_ack = 1'b0; bus.s_err = 1'b0; bus.s_dat_r = '0;
    for (int i = 0; i < NM; i++) begin
      bus.m_adr[i*AW +: AW]   = 32'hA000_0000 | 32'(i);
      bus.m_dat_w[i*DW +: DW] = 32'hD000_0000 | 32'(i);
      bus.m_sel[i*4 +: 4]     = 4'(1 << i);
      bus.m_bte[i*2 +: 2]     = 2'(i);
    end

    // ---- vector table -------------------------------------------------
    // Reset, then masters 1 and 2 request: 1 first, one IDLE gap, then 2.
    add(0, 4'h0, 4'h0, 0, 0,  0, 0, 0, 0, 4'h0, 4'h0, 0);
    add(1, 4'h6, 4'h6, 0, 0,  0, 0, 0, 0, 4'h0, 4'h0, 0);
    add(1, 4'h6, 4'h6, 0, 0,  1, 1, 1, 1, 4'h0, 4'h0, 0);
    add(1, 4'h6, 4'h6, 1, 0,  1, 1, 1, 1, 4'h2, 4'h0, 0);
    add(1, 4'h4, 4'h4, 0, 0,  1, 1, 0, 0, 4'h0, 4'h0, 0);
    add(1, 4'h4, 4'h4, 0, 0,  0, 0, 0, 0, 4'h0, 4'h0, 0);
    add(1, 4'h4, 4'h4, 1, 0,  1, 2, 1, 1, 4'h4, 4'h0, 0);
    add(1, 4'h0, 4'h0, 0, 0,  1, 2, 0, 0, 4'h0, 4'h0, 0);
    add(1, 4'h0, 4'h0, 0, 0,  0, 0, 0, 0, 4'h0, 4'h0, 0);
    // Reset again; all four request, ACK on the 3rd granted cycle: 0,1,2,3,0.
    add(0, 4'h0, 4'h0, 0, 0,  0, 0, 0, 0, 4'h0, 4'h0, 0);
    add(1, 4'hF, 4'hF, 0, 0,  0, 0, 0, 0, 4'h0, 4'h0, 0);
    for (int m = 0; m < 4; m++) begin
      add(1, 4'hF, 4'hF, 0, 0,  1, 2'(m), 1, 1, 4'h0, 4'h0, 0);
      add(1, 4'hF, 4'hF, 0, 0,  1, 2'(m), 1, 1, 4'h0, 4'h0, 0);
      add(1, 4'hF, 4'hF, 1, 0,  1, 2'(m), 1, 1, 4'(1 << m), 4'h0, 0);
      add(1, 4'hF & ~4'(1 << m), 4'hF & ~4'(1 << m), 0, 0,  1, 2'(m), 0, 0, 4'h0, 4'h0, 0);
      add(1, 4'hF, 4'hF, 0, 0,  0, 0, 0, 0, 4'h0, 4'h0, 0);
    end
    add(1, 4'hF, 4'hF, 0, 0,  1, 0, 1, 1, 4'h0, 4'h0, 0);
    add(1, 4'h0, 4'h0, 0, 0,  1, 0, 0, 0, 4'h0, 4'h0, 0);
    add(1, 4'h0, 4'h0, 0, 0,  0, 0, 0, 0, 4'h0, 4'h0, 0);
    // Watchdog: master 2, slave never answers; ERR on the 8th stalled cycle.
    add(1, 4'h4, 4'h4, 0, 0,  0, 0, 0, 0, 4'h0, 4'h0, 0);
    for (int k = 0; k < TO - 1; k++)
      add(1, 4'h4, 4'h4, 0, 0,  1, 2, 1, 1, 4'h0, 4'h0, 0);
    add(1, 4'h4, 4'h4, 0, 0,  1, 2, 1, 1, 4'h0, 4'h4, 1);
    add(1, 4'h4, 4'h4, 1, 0,  1, 2, 0, 0, 4'h0, 4'h0, 0);
    add(1, 4'h4, 4'h4, 0, 1,  1, 2, 0, 0, 4'h0, 4'h0, 0);
    add(1, 4'h0, 4'h0, 0, 0,  1, 2, 0, 0, 4'h0, 4'h0, 0);
    add(1, 4'h0, 4'h0, 0, 0,  0, 0, 0, 0, 4'h0, 4'h0, 0);
    // Watchdog: master 3, ACK arrives on the terminal-count cycle and wins.
    add(1, 4'h8, 4'h8, 0, 0,  0, 0, 0, 0, 4'h0, 4'h0, 0);
    for (int k = 0; k < TO - 1; k++)
      add(1, 4'h8, 4'h8, 0, 0,  1, 3, 1, 1, 4'h0, 4'h0, 0);
    add(1, 4'h8, 4'h8, 1, 0,  1, 3, 1, 1, 4'h8, 4'h0, 0);
    add(1, 4'h8, 4'h8, 1, 1,  1, 3, 1, 1, 4'h8, 4'h8, 0);
    add(1, 4'h8, 4'h0, 0, 0,  1, 3, 1, 0, 4'h0, 4'h0, 0);
    add(1, 4'h0, 4'h0, 1, 0,  1, 3, 0, 0, 4'h8, 4'h0, 0);
    add(1, 4'h0, 4'h0, 0, 0,  0, 0, 0, 0, 4'h0, 4'h0, 0);

    #2;
    chk("reset_outputs", 128'(ctrl_now()), 128'h0);

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1;
      rstn        = vq[i].rn;
      bus.m_cyc   = vq[i].cyc;
      bus.m_stb   = vq[i].stb;
      bus.s_ack   = vq[i].ack;
      bus.s_err   = vq[i].err;
      bus.s_dat_r = 32'h5A00_0000 | 32'(i);
      @(negedge clk);
      chk($sformatf("vec%0d_ctrl", i), 128'(ctrl_now()),
          128'({vq[i].e_gv, vq[i].e_id, vq[i].e_scyc, vq[i].e_sstb,
                vq[i].e_mack, vq[i].e_merr, vq[i].e_to}));
      chk($sformatf("vec%0d_dat_r", i), 128'(bus.m_dat_r), 128'(32'h5A00_0000 | 32'(i)));
      if (vq[i].e_scyc)
        chk($sformatf("vec%0d_mux", i),
            128'({bus.s_adr, bus.s_dat_w, bus.s_sel, bus.s_we, bus.s_bte, bus.s_cti}),
            128'({32'hA000_0000 | 32'(vq[i].e_id), 32'hD000_0000 | 32'(vq[i].e_id),
                  4'(1 << vq[i].e_id), vq[i].e_id[0], vq[i].e_id, 3'b000}));
    end

    // ---- burst by master 3 while master 0 waits -----------------------
    rstn = 1'b0;
    bus.m_cyc = '0; bus.m_stb = '0; bus.s_ack = 1'b0; bus.s_err = 1'b0;
    tick();
    rstn = 1'b1;
    bus.m_cyc = 4'h8; bus.m_stb = 4'h8;
    bus.m_cti[9 +: 3] = 3'b010;
    @(negedge clk);
    chk("burst_idle", 128'(gnt_valid), 128'(1'b0));
    tick();
    for (int b = 1; b <= 4; b++) begin
      bus.m_cyc = 4'h9; bus.m_stb = 4'h9; bus.s_ack = 1'b1;
      bus.m_cti[9 +: 3] = (b == 4) ? 3'b111 : 3'b010;
      @(negedge clk);
      chk($sformatf("burst_beat%0d", b), 128'({gnt_valid, gnt_id, bus.m_ack, bus.s_cti}),
          128'({1'b1, 2'd3, 4'h8, (b == 4) ? 3'b111 : 3'b010}));
      tick();
    end
    bus.m_cyc = 4'h1; bus.m_stb = 4'h1; bus.s_ack = 1'b0;
    bus.m_cti[9 +: 3] = 3'b000;
    @(negedge clk);
    chk("burst_release", 128'({gnt_valid, gnt_id, bus.s_cyc, bus.m_ack}),
        128'({1'b1, 2'd3, 1'b0, 4'h0}));
    tick();
    @(negedge clk);
    chk("burst_gap", 128'({gnt_valid, bus.s_cyc}), 128'(2'b00));
    tick();
    bus.s_ack = 1'b1;
    @(negedge clk);
    chk("burst_next_m0", 128'({gnt_valid, gnt_id, bus.s_cyc, bus.m_ack}),
        128'({1'b1, 2'd0, 1'b1, 4'h1}));
    tick();
    bus.m_cyc = '0; bus.m_stb = '0; bus.s_ack = 1'b0;
    tick();

    // ---- asynchronous reset in the middle of a burst ------------------
    bus.m_cyc = 4'h1; bus.m_stb = 4'h1;
    tick();
    bus.s_ack = 1'b1;
    bus.m_cti[0 +: 3] = 3'b010;
    @(negedge clk);
    chk("rst_pre_gnt", 128'({gnt_valid, gnt_id, bus.m_ack}), 128'({1'b1, 2'd0, 4'h1}));
    #2;
    rstn = 1'b0;
    bus.m_cyc = 4'h3; bus.m_stb = 4'h3;
    #1;
    chk("rst_async", 128'(ctrl_now()), 128'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    bus.s_ack = 1'b0;
    bus.m_cti[0 +: 3] = 3'b000;
    @(negedge clk);
    chk("rst_release_idle", 128'(gnt_valid), 128'(1'b0));
    tick();
    @(negedge clk);
    chk("rst_prio_m0", 128'({gnt_valid, gnt_id}), 128'({1'b1, 2'd0}));
    tick();
    bus.m_cyc = '0; bus.m_stb = '0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
